// File: rtl/t_mod_counter_pkg.sv
// rtl/t_mod_counter_pkg.sv - shared clock-stage constants, adjust FSM encoding and BCD split helper
package t_mod_counter_pkg;

  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HOUR = 24;

  localparam int REPEAT_DELAY_DEF  = 25_000_000;
  localparam int REPEAT_PERIOD_DEF = 5_000_000;

  typedef enum logic [1:0] {
    ADJ_IDLE   = 2'd0,
    ADJ_PRESS  = 2'd1,
    ADJ_REPEAT = 2'd2
  } adj_state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

  // Counts never exceed 99, so a 7-bit value covers every legal modulus.
  function automatic bcd_pair_t bcd_split(input logic [6:0] value);
    bcd_pair_t r;
    r.tens  = 4'(value / 7'd10);
    r.units = 4'(value % 7'd10);
    return r;
  endfunction

endpackage

// File: rtl/led7_decoder.sv
// rtl/led7_decoder.sv - BCD digit to active-high 7-segment pattern, bit 0 = segment a
module led7_decoder (
  input  logic       enable_i,
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    if (enable_i) begin
      case (digit_i)
        4'd0:    seg_o = 7'h3F;
        4'd1:    seg_o = 7'h06;
        4'd2:    seg_o = 7'h5B;
        4'd3:    seg_o = 7'h4F;
        4'd4:    seg_o = 7'h66;
        4'd5:    seg_o = 7'h6D;
        4'd6:    seg_o = 7'h7D;
        4'd7:    seg_o = 7'h07;
        4'd8:    seg_o = 7'h7F;
        4'd9:    seg_o = 7'h6F;
        default: seg_o = 7'h00;
      endcase
    end
  end

endmodule

// File: rtl/t_mod_counter_adj_repeat.sv
// rtl/t_mod_counter_adj_repeat.sv - adjust button edge detect with hold-to-auto-repeat timer
module t_mod_counter_adj_repeat
  import t_mod_counter_pkg::*;
#(
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic adj_n_i,
  output logic a_evt_o
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

  adj_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          adj_q;

  // adj_q keeps tracking the button through reset, so a button already held
  // when reset releases is not mistaken for a fresh press.
  always_ff @(posedge clk_i) begin
    adj_q <= adj_n_i;
    if (reset_i) begin
      state_q <= ADJ_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    a_evt_o = 1'b0;
    case (state_q)
      ADJ_IDLE: begin
        if (adj_q && !adj_n_i) begin
          a_evt_o = 1'b1;
          timer_d = '0;
          state_d = ADJ_PRESS;
        end
      end
      ADJ_PRESS: begin
        if (adj_n_i) begin
          state_d = ADJ_IDLE;
          timer_d = '0;
        end else if (timer_q == DELAY_LAST) begin
          a_evt_o = 1'b1;
          timer_d = '0;
          state_d = ADJ_REPEAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ADJ_REPEAT: begin
        if (adj_n_i) begin
          state_d = ADJ_IDLE;
          timer_d = '0;
        end else if (timer_q == PERIOD_LAST) begin
          a_evt_o = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ADJ_IDLE;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/t_mod_counter.sv
// rtl/t_mod_counter.sv - modulo time-digit counter with carry chaining, button adjust and 7-segment outputs
module t_mod_counter
  import t_mod_counter_pkg::*;
#(
  parameter int MODULUS       = MOD_HOUR,
  parameter int WIDTH         = 6,
  parameter int INIT          = 23,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             carry_in,
  input  logic             hold,
  input  logic             adj_n,
  input  logic             adj_up,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic [3:0]       tens,
  output logic [3:0]       units,
  output logic [6:0]       led_tens,
  output logic [6:0]       led_units
);

  localparam logic [WIDTH-1:0] LAST   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             carry_in_q;
  logic             c_evt;
  logic             a_evt;
  logic [6:0]       count_ext;
  bcd_pair_t        digits;

  assign c_evt = carry_in & ~carry_in_q & ~hold;

  t_mod_counter_adj_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_adj (
    .clk_i   (clk50),
    .reset_i (reset),
    .adj_n_i (adj_n),
    .a_evt_o (a_evt)
  );

  // Adjust wins over a coincident carry step; an out-of-range count always recovers to 0.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (a_evt) begin
      if (count_q > LAST) begin
        count_d = '0;
      end else if (adj_up) begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
      end else begin
        count_d = (count_q == '0) ? LAST : count_q - 1'b1;
      end
    end else if (c_evt) begin
      if (count_q > LAST) begin
        count_d = '0;
      end else if (count_q == LAST) begin
        count_d = '0;
        carry_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // carry_in_q samples even while hold=1 so releasing hold never fakes an edge.
  always_ff @(posedge clk50) begin
    if (reset) begin
      count_q    <= INIT_V;
      carry_q    <= 1'b0;
      carry_in_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      carry_in_q <= carry_in;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;

  assign count_ext = 7'(count_q);
  assign digits    = bcd_split(count_ext);
  assign tens      = digits.tens;
  assign units     = digits.units;

  led7_decoder u_led_tens (
    .enable_i (1'b1),
    .digit_i  (digits.tens),
    .seg_o    (led_tens)
  );

  led7_decoder u_led_units (
    .enable_i (1'b1),
    .digit_i  (digits.units),
    .seg_o    (led_units)
  );

endmodule

// File: tb/tb_t_mod_counter.sv
// tb/tb_t_mod_counter.sv - scoreboard bench for t_mod_counter (hour stage and a 60-modulus stage)
module tb_t_mod_counter;
  import t_mod_counter_pkg::*;

  typedef struct packed {
    int   cnt;
    logic co;
  } exp_t;

  logic clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  logic       reset, carry_in, hold, adj_n, adj_up;
  logic [5:0] count;
  logic       carry_out;
  logic [3:0] tens, units;
  logic [6:0] led_tens, led_units;

  logic       reset_b, carry_in_b, hold_b, adj_n_b, adj_up_b;
  logic [5:0] count_b;
  logic       carry_out_b;
  logic [3:0] tens_b, units_b;
  logic [6:0] led_tens_b, led_units_b;

  int errors = 0;
  int checks = 0;
  int ma, mb;
  exp_t q_a[$];
  exp_t q_b[$];

  t_mod_counter #(
    .MODULUS(MOD_HOUR), .WIDTH(6), .INIT(23), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut (
    .clk50(clk50), .reset(reset), .carry_in(carry_in), .hold(hold), .adj_n(adj_n),
    .adj_up(adj_up), .count(count), .carry_out(carry_out), .tens(tens), .units(units),
    .led_tens(led_tens), .led_units(led_units)
  );

  t_mod_counter #(
    .MODULUS(MOD_SEC), .WIDTH(6), .INIT(59), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut_b (
    .clk50(clk50), .reset(reset_b), .carry_in(carry_in_b), .hold(hold_b), .adj_n(adj_n_b),
    .adj_up(adj_up_b), .count(count_b), .carry_out(carry_out_b), .tens(tens_b), .units(units_b),
    .led_tens(led_tens_b), .led_units(led_units_b)
  );

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic int m_up(input int c, input int m);
    return (c == m - 1) ? 0 : c + 1;
  endfunction

  function automatic int m_down(input int c, input int m);
    return (c == 0) ? m - 1 : c - 1;
  endfunction

  // Each count change is popped against the queue; quiet cycles must carry no pulse.
  int   prev_a = 0, prev_b = 0;
  logic rst_prev_a = 1'b1, rst_prev_b = 1'b1;
  always @(negedge clk50) begin
    exp_t e;
    if (!rst_prev_a) begin
      checks++;
      if (int'(count) != prev_a) begin
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a_unexpected_step: count=%0d carry_out=%b, required no step", count, carry_out);
        end else begin
          e = q_a.pop_front();
          if (int'(count) !== e.cnt || carry_out !== e.co) begin
            errors++;
            $display("FAIL sb_a_step: count=%0d carry_out=%b, required count=%0d carry_out=%b", count, carry_out, e.cnt, e.co);
          end
        end
      end else if (carry_out !== 1'b0) begin
        errors++;
        $display("FAIL sb_a_stray_carry: carry_out=%b, required 0", carry_out);
      end
    end
    prev_a = int'(count);
    rst_prev_a = reset;
    if (!rst_prev_b) begin
      checks++;
      if (int'(count_b) != prev_b) begin
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_unexpected_step: count=%0d carry_out=%b, required no step", count_b, carry_out_b);
        end else begin
          e = q_b.pop_front();
          if (int'(count_b) !== e.cnt || carry_out_b !== e.co) begin
            errors++;
            $display("FAIL sb_b_step: count=%0d carry_out=%b, required count=%0d carry_out=%b", count_b, carry_out_b, e.cnt, e.co);
          end
        end
      end else if (carry_out_b !== 1'b0) begin
        errors++;
        $display("FAIL sb_b_stray_carry: carry_out=%b, required 0", carry_out_b);
      end
    end
    prev_b = int'(count_b);
    rst_prev_b = reset_b;
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic push_a(input int cnt, input logic co);
    q_a.push_back('{cnt, co});
    ma = cnt;
  endtask

  task automatic push_b(input int cnt, input logic co);
    q_b.push_back('{cnt, co});
    mb = cnt;
  endtask

  task automatic carry_step_a();
    push_a(m_up(ma, 24), ma == 23);
    carry_in = 1'b1;
    tick();
    carry_in = 1'b0;
    tick();
  endtask

  task automatic press_a(input logic dir);
    push_a(dir ? m_up(ma, 24) : m_down(ma, 24), 1'b0);
    adj_up = dir;
    adj_n  = 1'b0;
    tick();
    tick();
    adj_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; carry_in = 1'b0; hold = 1'b0; adj_n = 1'b1; adj_up = 1'b1;
    reset_b = 1'b1; carry_in_b = 1'b0; hold_b = 1'b0; adj_n_b = 1'b1; adj_up_b = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    reset_b = 1'b0;
    ma = 23;
    mb = 59;
    checks++; if (count !== 6'd23) begin errors++; $display("FAIL reset_count: got %0d, required 23", count); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b, required 0", carry_out); end
    checks++; if (tens !== 4'd2 || units !== 4'd3) begin errors++; $display("FAIL reset_bcd: got %0d%0d, required 23", tens, units); end
    checks++; if (led_tens !== seg7(2) || led_units !== seg7(3)) begin errors++; $display("FAIL reset_led: got %h/%h, required %h/%h", led_tens, led_units, seg7(2), seg7(3)); end
    checks++; if (count_b !== 6'd59 || tens_b !== 4'd5 || units_b !== 4'd9) begin errors++; $display("FAIL reset_b: got %0d (%0d%0d), required 59", count_b, tens_b, units_b); end
  endtask

  task automatic test_carry_wrap();
    push_a(0, 1'b1);
    carry_in = 1'b1;
    tick();
    checks++; if (count !== 6'd0 || carry_out !== 1'b1) begin errors++; $display("FAIL wrap_step: got count=%0d carry=%b, required 0/1", count, carry_out); end
    checks++; if (tens !== 4'd0 || units !== 4'd0 || led_units !== seg7(0)) begin errors++; $display("FAIL wrap_bcd: got %0d%0d led %h, required 00 led %h", tens, units, led_units, seg7(0)); end
    carry_in = 1'b0;
    tick();
    checks++; if (carry_out !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL wrap_pulse_len: got count=%0d carry=%b, required 0/0", count, carry_out); end
    push_a(1, 1'b0);
    carry_in = 1'b1;
    tick();
    checks++; if (count !== 6'd1 || carry_out !== 1'b0) begin errors++; $display("FAIL carry_plus1: got count=%0d carry=%b, required 1/0", count, carry_out); end
    carry_in = 1'b0;
    tick();
  endtask

  task automatic test_hold();
    hold = 1'b1;
    repeat (3) begin
      carry_in = 1'b1;
      tick();
      carry_in = 1'b0;
      tick();
    end
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL hold_frozen: got %0d, required 1", count); end
    carry_in = 1'b1;
    tick();
    tick();
    hold = 1'b0;
    tick();
    tick();
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL hold_release_no_edge: got %0d, required 1", count); end
    carry_in = 1'b0;
    tick();
    push_a(2, 1'b0);
    carry_in = 1'b1;
    tick();
    checks++; if (count !== 6'd2) begin errors++; $display("FAIL hold_next_edge: got %0d, required 2", count); end
    carry_in = 1'b0;
    tick();
  endtask

  task automatic test_adjust_wrap();
    for (int i = 0; i < 24 && ma != 0; i++) carry_step_a();
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL adj_setup: got %0d, required 0", count); end
    push_a(23, 1'b0);
    adj_up = 1'b0;
    adj_n  = 1'b0;
    tick();
    checks++; if (count !== 6'd23 || carry_out !== 1'b0) begin errors++; $display("FAIL adj_down_wrap: got count=%0d carry=%b, required 23/0", count, carry_out); end
    tick();
    adj_n = 1'b1;
    tick();
    tick();
    push_a(0, 1'b0);
    adj_up = 1'b1;
    adj_n  = 1'b0;
    tick();
    checks++; if (count !== 6'd0 || carry_out !== 1'b0) begin errors++; $display("FAIL adj_up_wrap: got count=%0d carry=%b, required 0/0", count, carry_out); end
    tick();
    adj_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_auto_repeat();
    int exp_c;
    for (int i = 0; i < 24 && ma != 5; i++) carry_step_a();
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL rep_setup: got %0d, required 5", count); end
    for (int s = 0; s < 5; s++) push_a(ma + 1, 1'b0);
    adj_up = 1'b1;
    adj_n  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      exp_c = 6 + int'(k >= 4) + int'(k >= 6) + int'(k >= 8) + int'(k >= 10);
      checks++; if (int'(count) !== exp_c) begin errors++; $display("FAIL rep_cycle%0d: got %0d, required %0d", k, count, exp_c); end
    end
    adj_n = 1'b1;
    repeat (6) tick();
    checks++; if (count !== 6'd10) begin errors++; $display("FAIL rep_release: got %0d, required 10", count); end
  endtask

  task automatic test_simultaneous();
    repeat (5) press_a(1'b0);
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL sim_setup: got %0d, required 5", count); end
    push_a(6, 1'b0);
    adj_up   = 1'b1;
    adj_n    = 1'b0;
    carry_in = 1'b1;
    tick();
    checks++; if (count !== 6'd6 || carry_out !== 1'b0) begin errors++; $display("FAIL sim_step: got count=%0d carry=%b, required 6/0", count, carry_out); end
    adj_n    = 1'b1;
    carry_in = 1'b0;
    tick();
    tick();
    checks++; if (count !== 6'd6) begin errors++; $display("FAIL sim_dropped_carry: got %0d, required 6", count); end
  endtask

  task automatic test_reset_mid_repeat();
    push_b(0, 1'b0);
    push_b(1, 1'b0);
    push_b(2, 1'b0);
    adj_up_b = 1'b1;
    adj_n_b  = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (count_b !== 6'd2) begin errors++; $display("FAIL b_repeat: got %0d, required 2", count_b); end
    reset_b = 1'b1;
    tick();
    tick();
    mb = 59;
    checks++; if (count_b !== 6'd59 || carry_out_b !== 1'b0) begin errors++; $display("FAIL b_reset: got count=%0d carry=%b, required 59/0", count_b, carry_out_b); end
    reset_b = 1'b0;
    repeat (8) tick();
    checks++; if (count_b !== 6'd59) begin errors++; $display("FAIL b_held_after_reset: got %0d, required 59", count_b); end
    adj_n_b = 1'b1;
    tick();
    tick();
    push_b(0, 1'b1);
    carry_in_b = 1'b1;
    tick();
    checks++; if (count_b !== 6'd0 || carry_out_b !== 1'b1) begin errors++; $display("FAIL b_carry_wrap: got count=%0d carry=%b, required 0/1", count_b, carry_out_b); end
    carry_in_b = 1'b0;
    tick();
    checks++; if (carry_out_b !== 1'b0) begin errors++; $display("FAIL b_carry_len: got %b, required 0", carry_out_b); end
    push_b(1, 1'b0);
    adj_n_b = 1'b0;
    tick();
    checks++; if (count_b !== 6'd1) begin errors++; $display("FAIL b_fresh_press: got %0d, required 1", count_b); end
    adj_n_b = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_drain();
    @(negedge clk50);
    #1;
    checks++; if (q_a.size() != 0) begin errors++; $display("FAIL drain_a: %0d steps outstanding, required 0", q_a.size()); end
    checks++; if (q_b.size() != 0) begin errors++; $display("FAIL drain_b: %0d steps outstanding, required 0", q_b.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_carry_wrap();
    test_hold();
    test_adjust_wrap();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
